// File: rtl/imem_program_loader_if.sv
// Byte-stream handshake into the program loader. A byte transfers on a rising
// clk edge where in_valid and in_ready are both high; in_data is held while in_valid waits.
interface imem_program_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_program_loader.sv
// Streams big-endian bytes into 32-bit words and writes them sequentially into
// instruction memory, holding the core in reset until the image is complete.
module imem_program_loader #(
    parameter int ADDR_W    = 8,
    parameter bit BOOT_HOLD = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      num_words,
    imem_program_loader_if.slave in_s,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [31:0]          imem_wdata,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           checksum,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   num_q;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_cnt_inc;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_q;
    logic              accept;
    logic              start_ok;
    logic              last_byte;

    assign start_ok     = (state == S_IDLE) && start;
    assign accept       = (state == S_RECV) && in_s.in_valid;
    assign last_byte    = accept && (byte_cnt == 2'd3);
    assign word_cnt_inc = word_cnt + ONE_W;
    assign dbg_state    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_words == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (last_byte) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nxt = (word_cnt_inc == num_q) ? S_DONE : S_RECV;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_s.in_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        imem_we       = 1'b0;
        case (state)
            S_RECV: begin
                in_s.in_ready = 1'b1;
                busy          = 1'b1;
            end
            S_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q     <= '0;
            num_q      <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            word_q     <= '0;
            checksum   <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (start_ok) begin
                base_q   <= base_addr;
                num_q    <= num_words;
                word_cnt <= '0;
                byte_cnt <= '0;
                word_q   <= '0;
                checksum <= '0;
            end
            if (accept) begin
                word_q   <= {word_q[23:0], in_s.in_data};
                checksum <= checksum ^ in_s.in_data;
                byte_cnt <= byte_cnt + 2'd1;
            end
            // Address and data are captured with the 4th byte so they are stable for the whole WRITE cycle.
            if (last_byte) begin
                imem_addr  <= base_q + word_cnt[ADDR_W-1:0];
                imem_wdata <= {word_q[23:0], in_s.in_data};
            end
            if (state == S_WRITE) begin
                word_cnt <= word_cnt_inc;
            end
        end
    end

    // Core reset drops on the same edge the DONE pulse begins, including zero-length loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_reset <= BOOT_HOLD;
        end else if (state_nxt == S_DONE && state != S_DONE) begin
            cpu_reset <= 1'b0;
        end else if (start_ok) begin
            cpu_reset <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: load sequencing, write log, checksum,
// core-reset handshake, address wrap and asynchronous reset behaviour.
module tb_imem_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_words;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    imem_program_loader_if bus ();

    imem_program_loader #(.ADDR_W(8), .BOOT_HOLD(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .in_s       (bus),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- monitor / scoreboard state ----------------
    logic [39:0] wr_log[$];
    logic [39:0] exp_q[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          first_acc_cyc = 0;
    int          done_cyc = 0;
    logic        cpu_at_done = 1'b0;
    logic        cpu_before_done = 1'b0;
    logic        prev_cpu = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.in_valid && bus.in_ready) begin
            if (acc_cnt == 0) first_acc_cyc = cyc;
            acc_cnt = acc_cnt + 1;
        end
        if (imem_we) wr_log.push_back({imem_addr, imem_wdata});
        if (done) begin
            done_cyc        = cyc;
            cpu_at_done     = cpu_reset;
            cpu_before_done = prev_cpu;
        end
        prev_cpu = cpu_reset;
    end

    // ---------------- drivers ----------------
    task automatic do_start(input logic [7:0] b, input logic [8:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = 8'h00;
        num_words = 9'h000;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL push_timeout got in_ready=%0b want=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", bus.in_ready); end
        total++; if ({imem_we, imem_addr, imem_wdata} !== 41'd0) begin bad++; $display("FAIL rst_imem got=%0b/%h/%h want=0/00/00000000", imem_we, imem_addr, imem_wdata); end
        total++; if ({busy, done, checksum} !== 10'd0) begin bad++; $display("FAIL rst_flags got busy=%0b done=%0b cks=%h want=0/0/00", busy, done, checksum); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset got=%0b want=1", cpu_reset); end
        @(negedge clk);
        reset = 1'b0;
        // enter RECV, then assert reset mid-cycle with no clock edge
        do_start(8'h05, 9'd1);
        total++; if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rst_pre_recv got ready=%0b busy=%0b want=1/1", bus.in_ready, busy); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL rst_async got ready=%0b busy=%0b st=%0d want=0/0/0", bus.in_ready, busy, dbg_state); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_async_cpu got=%0b want=1", cpu_reset); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] img [8];
        logic [7:0] exp_cks;
        int t;
        img = '{8'h20, 8'h02, 8'h00, 8'h0A, 8'h20, 8'h03, 8'hFF, 8'hFF};
        exp_cks = 8'h00;
        foreach (img[i]) exp_cks = exp_cks ^ img[i];
        wr_log.delete();
        exp_q = '{40'h00_2002000A, 40'h01_2003FFFF};
        acc_cnt = 0;
        done_cyc = 0;
        do_start(8'h00, 9'd2);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%0b want=1", bus.in_ready); end
        foreach (img[i]) push_byte(img[i]);
        t = 0;
        while (done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_timeout got=%0b want=1", done); end
        @(negedge clk);
        total++; if (done_cyc - first_acc_cyc + 1 !== 11) begin bad++; $display("FAIL b2b_latency got=%0d want=11", done_cyc - first_acc_cyc + 1); end
        total++; if (checksum !== exp_cks) begin bad++; $display("FAIL b2b_checksum got=%h want=%h", checksum, exp_cks); end
        total++; if (cpu_before_done !== 1'b1 || cpu_at_done !== 1'b0) begin bad++; $display("FAIL b2b_cpu_reset got=%0b->%0b want=1->0", cpu_before_done, cpu_at_done); end
        total++; if (wr_log.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_wr_count got=%0d want=%0d", wr_log.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < wr_log.size()) begin
            total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_write%0d got=%h want=%h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_gapped_stream();
        logic [7:0] img [8];
        logic [7:0] exp_cks;
        int t;
        img = '{8'h20, 8'h02, 8'h00, 8'h0A, 8'h20, 8'h03, 8'hFF, 8'hFF};
        exp_cks = 8'h00;
        foreach (img[i]) exp_cks = exp_cks ^ img[i];
        wr_log.delete();
        exp_q = '{40'h00_2002000A, 40'h01_2003FFFF};
        do_start(8'h00, 9'd2);
        foreach (img[i]) begin
            push_byte(img[i]);
            if (i == 1) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL gap_we%0d got=%0b want=0", g, imem_we); end
                end
                @(posedge clk);
                #1;
            end
        end
        t = 0;
        while (done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL gap_done_timeout got=%0b want=1", done); end
        @(negedge clk);
        total++; if (checksum !== exp_cks) begin bad++; $display("FAIL gap_checksum got=%h want=%h", checksum, exp_cks); end
        total++; if (wr_log.size() !== exp_q.size()) begin bad++; $display("FAIL gap_wr_count got=%0d want=%0d", wr_log.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < wr_log.size()) begin
            total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL gap_write%0d got=%h want=%h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_wrap_zero();
        logic [7:0] img [12];
        int t;
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                8'h99, 8'hAA, 8'hBB, 8'hCC};
        wr_log.delete();
        exp_q = '{40'hFE_11223344, 40'hFF_55667788, 40'h00_99AABBCC};
        do_start(8'hFE, 9'd3);
        foreach (img[i]) push_byte(img[i]);
        t = 0;
        while (done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done_timeout got=%0b want=1", done); end
        @(negedge clk);
        total++; if (wr_log.size() !== exp_q.size()) begin bad++; $display("FAIL wrap_wr_count got=%0d want=%0d", wr_log.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < wr_log.size()) begin
            total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_write%0d got=%h want=%h", i, wr_log[i], exp_q[i]); end
        end
        // zero-length load
        wr_log.delete();
        do_start(8'h33, 9'd0);
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done got done=%0b busy=%0b want=1/0", done, busy); end
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL zero_cpu_reset got=%0b want=0", cpu_reset); end
        repeat (3) @(negedge clk);
        total++; if (wr_log.size() !== 0 || done !== 1'b0) begin bad++; $display("FAIL zero_no_write got writes=%0d done=%0b want=0/0", wr_log.size(), done); end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] img [6];
        int t;
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02};
        wr_log.delete();
        do_start(8'h40, 9'd3);
        foreach (img[i]) push_byte(img[i]);
        #3;
        reset = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL mid_rst_ctl got ready=%0b busy=%0b done=%0b st=%0d want=0/0/0/0", bus.in_ready, busy, done, dbg_state); end
        total++; if (cpu_reset !== 1'b1 || checksum !== 8'h00) begin bad++; $display("FAIL mid_rst_cpu_cks got cpu=%0b cks=%h want=1/00", cpu_reset, checksum); end
        total++; if ({imem_we, imem_addr, imem_wdata} !== 41'd0) begin bad++; $display("FAIL mid_rst_imem got=%0b/%h/%h want=0/00/00000000", imem_we, imem_addr, imem_wdata); end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (wr_log.size() !== 1) begin bad++; $display("FAIL mid_rst_wr_count got=%0d want=1", wr_log.size()); end
        if (wr_log.size() > 0) begin
            total++; if (wr_log[0] !== 40'h40_AABBCCDD) begin bad++; $display("FAIL mid_rst_write0 got=%h want=40aabbccdd", wr_log[0]); end
        end
        // fresh one-word load after the aborted one
        wr_log.delete();
        do_start(8'h20, 9'd1);
        push_byte(8'h0C); push_byte(8'h00); push_byte(8'h00); push_byte(8'h08);
        t = 0;
        while (done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL fresh_done_timeout got=%0b want=1", done); end
        @(negedge clk);
        total++; if (wr_log.size() !== 1) begin bad++; $display("FAIL fresh_wr_count got=%0d want=1", wr_log.size()); end
        if (wr_log.size() > 0) begin
            total++; if (wr_log[0] !== 40'h20_0C000008) begin bad++; $display("FAIL fresh_write got=%h want=200c000008", wr_log[0]); end
        end
    endtask

    task automatic test_ignored_inputs();
        int t;
        // previous load was 0C 00 00 08
        acc_cnt = 0;
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (acc_cnt !== 0 || checksum !== 8'h04) begin bad++; $display("FAIL idle_valid got acc=%0d cks=%h want=0/04", acc_cnt, checksum); end
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL idle_cpu_low got=%0b want=0", cpu_reset); end
        bus.in_valid = 1'b0;
        wr_log.delete();
        do_start(8'h10, 9'd1);
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL start_cpu_rise got=%0b want=1", cpu_reset); end
        // start pulse while busy must not relatch parameters
        start = 1'b1; base_addr = 8'h80; num_words = 9'd5;
        @(posedge clk);
        #1;
        start = 1'b0; base_addr = 8'h00; num_words = 9'd0;
        push_byte(8'h3C); push_byte(8'h01); push_byte(8'h10); push_byte(8'h00);
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        t = 0;
        while (done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done_timeout got=%0b want=1", done); end
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (acc_cnt !== 4) begin bad++; $display("FAIL ign_accepts got=%0d want=4", acc_cnt); end
        total++; if (checksum !== (8'h3C ^ 8'h01 ^ 8'h10 ^ 8'h00)) begin bad++; $display("FAIL ign_checksum got=%h want=2d", checksum); end
        total++; if (wr_log.size() !== 1) begin bad++; $display("FAIL ign_wr_count got=%0d want=1", wr_log.size()); end
        if (wr_log.size() > 0) begin
            total++; if (wr_log[0] !== 40'h10_3C011000) begin bad++; $display("FAIL ign_write got=%h want=103c011000", wr_log[0]); end
        end
        total++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL ign_idle got busy=%0b st=%0d want=0/0", busy, dbg_state); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = 8'h00;
        num_words    = 9'h000;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_gapped_stream();
        test_wrap_zero();
        test_reset_mid_load();
        test_ignored_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
